// File: rtl/fifo_ctl_pkg.sv
// Shared register map, status/error bit positions and control/error types
// for sync_fifo_ctl.
package fifo_ctl_pkg;

   localparam int ADDR_CTRL   = 0;
   localparam int ADDR_STATUS = 1;
   localparam int ADDR_AF_THR = 2;
   localparam int ADDR_AE_THR = 3;
   localparam int ADDR_ERR    = 4;

   // STATUS flag positions are offsets above the level field [AW:0]
   localparam int ST_EMPTY_OFS = 1;
   localparam int ST_FULL_OFS  = 2;
   localparam int ST_AE_OFS    = 3;
   localparam int ST_AF_OFS    = 4;

   localparam int ERR_OVF = 0;
   localparam int ERR_UDF = 1;

   typedef struct packed {
      logic flush;
   } ctrl_t;

   typedef struct packed {
      logic udf;
      logic ovf;
   } err_t;

endpackage

// File: rtl/fifo_ram_1c.sv
// DEPTH x DW simple dual-port storage. Synchronous write; read port is
// registered by default, combinational when FIFO_FWFT_EN is defined.
module fifo_ram_1c #(
   parameter int DW = 32,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data
);

   logic [DW-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

`ifdef FIFO_FWFT_EN
   logic unused_ok;
   assign unused_ok = &{1'b0, rd_en, rst_n};
   assign rd_data   = mem[rd_addr];
`else
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_addr];
   end
`endif

endmodule

// File: rtl/sync_fifo_ctl.sv
// Single-clock FIFO with register-bus control: thresholds, level readout,
// sticky OVF/UDF flags and soft flush. FIFO_FWFT_EN selects fall-through dout.
module sync_fifo_ctl
   import fifo_ctl_pkg::*;
#(
   parameter int DW     = 32,
   parameter int AW     = 4,
   parameter int REG_DW = 32,
   parameter int REG_AW = 8,
   parameter int AF_RST = 2**AW - 2,
   parameter int AE_RST = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              reg_req,
   input  logic              reg_wr,
   input  logic [REG_AW-1:0] reg_addr,
   input  logic [REG_DW-1:0] reg_wdata,
   output logic [REG_DW-1:0] reg_rdata,
   input  logic [DW-1:0]     din,
   input  logic              we,
   output logic [DW-1:0]     dout,
   input  logic              re,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty
);

   localparam logic [AW:0] DEPTH_L = (AW+1)'(2**AW);

   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   level, af_thr, ae_thr;
   err_t          err, err_set, err_clr;
   ctrl_t         ctrl_wr;
   logic          reg_wr_acc, reg_rd_acc;
   logic          wr_acc, rd_acc;
   logic [DW-1:0] ram_q;
   logic [REG_DW-1:0] status_word;
   logic          unused_ok;

   assign unused_ok = &{1'b0, reg_wdata[REG_DW-1:AW+1]};

   assign reg_wr_acc = reg_req & reg_wr;
   assign reg_rd_acc = reg_req & ~reg_wr;

   assign ctrl_wr.flush = reg_wr_acc && (reg_addr == REG_AW'(ADDR_CTRL)) && reg_wdata[0];

   assign full         = (level == DEPTH_L);
   assign empty        = (level == '0);
   assign almost_full  = (level >= af_thr);
   assign almost_empty = (level <= ae_thr);

   // A flush cycle swallows data-side requests entirely, errors included
   assign wr_acc = we & ~full  & ~ctrl_wr.flush;
   assign rd_acc = re & ~empty & ~ctrl_wr.flush;

   assign err_set.ovf = we & full  & ~ctrl_wr.flush;
   assign err_set.udf = re & empty & ~ctrl_wr.flush;
   assign err_clr     = (reg_wr_acc && (reg_addr == REG_AW'(ADDR_ERR)))
                        ? err_t'(reg_wdata[1:0]) : err_t'(2'b00);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (ctrl_wr.flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
         if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_acc, rd_acc})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         af_thr <= (AW+1)'(AF_RST);
         ae_thr <= (AW+1)'(AE_RST);
         err    <= '0;
      end else begin
         if (reg_wr_acc && (reg_addr == REG_AW'(ADDR_AF_THR))) af_thr <= reg_wdata[AW:0];
         if (reg_wr_acc && (reg_addr == REG_AW'(ADDR_AE_THR))) ae_thr <= reg_wdata[AW:0];
         // set after clear so a same-cycle new error survives W1C
         err <= err_t'((err & ~err_clr) | err_set);
      end
   end

   always_comb begin
      status_word                   = '0;
      status_word[AW:0]             = level;
      status_word[AW+ST_EMPTY_OFS]  = empty;
      status_word[AW+ST_FULL_OFS]   = full;
      status_word[AW+ST_AE_OFS]     = almost_empty;
      status_word[AW+ST_AF_OFS]     = almost_full;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reg_rdata <= '0;
      end else if (reg_rd_acc) begin
         reg_rdata <= '0;
         if (reg_addr == REG_AW'(ADDR_STATUS)) reg_rdata <= status_word;
         if (reg_addr == REG_AW'(ADDR_AF_THR)) reg_rdata <= REG_DW'(af_thr);
         if (reg_addr == REG_AW'(ADDR_AE_THR)) reg_rdata <= REG_DW'(ae_thr);
         if (reg_addr == REG_AW'(ADDR_ERR))    reg_rdata <= REG_DW'(err);
      end
   end

   fifo_ram_1c #(.DW(DW), .AW(AW)) u_ram (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_acc),
      .wr_addr (wr_ptr),
      .wr_data (din),
      .rd_en   (rd_acc),
      .rd_addr (rd_ptr),
      .rd_data (ram_q)
   );

`ifdef FIFO_FWFT_EN
   assign dout = empty ? '0 : ram_q;
`else
   assign dout = ram_q;
`endif

endmodule
